fir_control: RTL and testbench
==============================

FIR_CONTROL -- requirements
Module: fir_control

Interface
REQ-001 SHALL have parameter MAX_TAPS, default 16, giving the datapath tap capacity; TW = $clog2(MAX_TAPS).
REQ-002 SHALL have clk  in  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have the configuration ports:
- cfg_start  in  1  start-configuration pulse.
- cfg_tap_count  in  TW  requested tap count.
- cfg_stop  in  1  end-of-stream request.
REQ-005 SHALL have the coefficient stream ports:
- s_coeff_valid  in  1.
- s_coeff_data  in  32 signed.
- s_coeff_ready  out  1.
REQ-006 SHALL have the sample input stream ports:
- s_in_valid  in  1.
- s_in_data  in  32 signed.
- s_in_ready  out  1.
REQ-007 SHALL have the result stream ports:
- m_out_valid  out  1.
- m_out_data  out  32 signed.
- m_out_ready  in  1.
REQ-008 SHALL have the datapath drive ports:
- dp_rstn  out  1  active-low datapath reset.
- dp_tap_count  out  TW.
- dp_input_data_valid  out  1.
- dp_input_data  out  32.
- dp_coeff_data_valid  out  1.
- dp_coeff_data  out  32.
- dp_compute  out  1.
REQ-009 SHALL have the datapath return ports:
- dp_output_data  in  32 signed.
- dp_output_data_valid  in  1.
REQ-010 SHALL have the status ports:
- busy  out  1  state != IDLE.
- cfg_err  out  1  sticky illegal-tap-count flag.
- state  out  2  current state encoding.

Function
REQ-011 SHALL implement four states: IDLE=0, LOAD=1, RUN=2, DRAIN=3.
REQ-012 SHALL, in IDLE on cfg_start with cfg_tap_count in 2..MAX_TAPS-1, latch the tap count into dp_tap_count, assert dp_rstn=0 for exactly that one cycle, clear cfg_err, and go to LOAD.
REQ-013 SHALL, in IDLE on cfg_start with cfg_tap_count outside 2..MAX_TAPS-1, set cfg_err=1 and remain in IDLE with dp_tap_count unchanged.
REQ-014 SHALL ignore cfg_start outside IDLE and ignore cfg_stop outside RUN.
REQ-015 SHALL, in LOAD, hold s_coeff_ready=1 except during the dp_rstn pulse cycle.
REQ-016 SHALL, in LOAD, forward each accepted beat (s_coeff_valid and s_coeff_ready) combinationally as dp_coeff_data_valid=1 with dp_coeff_data=s_coeff_data.
REQ-017 SHALL count LOAD handshakes with its own counter and move to RUN on the cycle after handshake number dp_tap_count; s_coeff_ready=0 in every other state.
REQ-018 SHALL, in RUN, drive dp_compute=1 and forward each accepted sample as dp_input_data_valid=1 with dp_input_data=s_in_data.
REQ-019 SHALL keep a 2-entry result FIFO and a 1-bit in-flight flag, set in the cycle after a sample handshake (datapath latency is 1 cycle).
REQ-020 SHALL drive s_in_ready=1 only in RUN and only when (fifo_count + in_flight) < 2, so no datapath result is ever dropped.
REQ-021 SHALL push dp_output_data into the FIFO only when dp_output_data_valid=1; the priming results (the first dp_tap_count-1 samples) are discarded.
REQ-022 SHALL make m_out_valid equal to FIFO non-empty with m_out_data at the FIFO head; a pop occurs on m_out_valid and m_out_ready.
REQ-023 SHALL support a push and a pop in the same cycle with the count unchanged, including when the FIFO is full.
REQ-024 SHALL hold m_out_data stable while m_out_valid=1 and m_out_ready=0.
REQ-025 SHALL, on cfg_stop in RUN, go to DRAIN and drop s_in_ready in that same cycle; a sample handshaking in the cfg_stop cycle is still accepted.
REQ-026 SHALL, in DRAIN, keep dp_compute=0 and return to IDLE on the first cycle with in_flight=0 and the FIFO empty.
REQ-027 SHALL keep all dp_*_valid outputs at 0 in IDLE and DRAIN.

Reset
REQ-028 SHALL, while rst=1, force state=IDLE, all FIFO entries and counters to 0, in_flight=0, cfg_err=0, dp_tap_count=0, every valid and ready output to 0, and dp_rstn=0.
REQ-029 SHALL, on rst asserted in any state, abort that state with no further datapath writes; dp_rstn returns to 1 in the first cycle after rst deasserts.

Verification
REQ-030 SHALL cover a happy path: cfg_tap_count=4, four coefficients of 1, twelve samples of 5 with m_out_ready=1 -> exactly 9 results, each value 20, then cfg_stop -> DRAIN -> IDLE, busy=0.
REQ-031 SHALL cover illegal configuration: cfg_tap_count=0, 1 and MAX_TAPS-1+1 wrap cases -> cfg_err=1, state stays 0, no dp_rstn pulse; a later legal cfg_start clears cfg_err.
REQ-032 SHALL cover backpressure: tap count 2 with m_out_ready=0 -> at most 2 results buffered, s_in_ready=0 once fifo_count+in_flight=2; on release, results come out in order with none lost or duplicated.
REQ-033 SHALL cover simultaneous push and pop: FIFO full and m_out_ready=1 with a result arriving in the same cycle -> count stays 2 and ordering is preserved.
REQ-034 SHALL cover reset mid-LOAD: rst after 2 of 4 coefficients -> IDLE; a new configuration then loads 4 fresh coefficients and the outputs match the new coefficients only.
REQ-035 SHALL cover stop during backpressure: cfg_stop with 2 results queued -> DRAIN persists until both are popped, then IDLE.

Source files
------------

// File: rtl/fir_control.sv
// Sequencer for an external FIR datapath: validates the tap count, streams coefficients, then
// streams samples while buffering results in a 2-deep FIFO so none is lost under backpressure.
module fir_control #(
  parameter int unsigned MAX_TAPS = 16,
  localparam int unsigned TW = $clog2(MAX_TAPS)
) (
  input  logic               clk,
  input  logic               rst,
  // configuration
  input  logic               cfg_start,
  input  logic [TW-1:0]      cfg_tap_count,
  input  logic               cfg_stop,
  // coefficient stream
  input  logic               s_coeff_valid,
  input  logic signed [31:0] s_coeff_data,
  output logic               s_coeff_ready,
  // sample stream
  input  logic               s_in_valid,
  input  logic signed [31:0] s_in_data,
  output logic               s_in_ready,
  // result stream
  output logic               m_out_valid,
  output logic signed [31:0] m_out_data,
  input  logic               m_out_ready,
  // datapath drive
  output logic               dp_rstn,
  output logic [TW-1:0]      dp_tap_count,
  output logic               dp_input_data_valid,
  output logic [31:0]        dp_input_data,
  output logic               dp_coeff_data_valid,
  output logic [31:0]        dp_coeff_data,
  output logic               dp_compute,
  // datapath return
  input  logic signed [31:0] dp_output_data,
  input  logic               dp_output_data_valid,
  // status
  output logic               busy,
  output logic               cfg_err,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StRun   = 2'd2,
    StDrain = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TW-1:0]      tap_q;
  logic [TW-1:0]      coef_cnt_q;
  logic               pulse_q;
  logic               cfg_err_q;
  logic               in_flight_q;
  logic signed [31:0] fifo_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         cnt_q;

  logic tap_legal, start_ok, coeff_hs, in_hs, push, pop;

  assign tap_legal = (cfg_tap_count >= TW'(2)) && (cfg_tap_count <= TW'(MAX_TAPS - 1));
  assign start_ok  = (state_q == StIdle) && cfg_start && tap_legal;

  // Ready/valid outputs are gated by rst so they read 0 throughout reset, not just after it.
  assign s_coeff_ready = !rst && (state_q == StLoad) && !pulse_q;
  assign s_in_ready    = !rst && (state_q == StRun) &&
                         (({1'b0, cnt_q} + {2'b00, in_flight_q}) < 3'd2);
  assign coeff_hs      = s_coeff_valid && s_coeff_ready;
  assign in_hs         = s_in_valid && s_in_ready;
  assign m_out_valid   = !rst && (cnt_q != 2'd0);
  assign m_out_data    = fifo_q[rd_ptr_q];
  assign pop           = m_out_valid && m_out_ready;
  assign push          = !rst && dp_output_data_valid && ((cnt_q != 2'd2) || pop);

  assign dp_rstn             = !(rst || pulse_q);
  assign dp_tap_count        = tap_q;
  assign dp_coeff_data_valid = coeff_hs;
  assign dp_coeff_data       = s_coeff_data;
  assign dp_input_data_valid = in_hs;
  assign dp_input_data       = s_in_data;
  assign dp_compute          = !rst && (state_q == StRun);

  assign busy    = (state_q != StIdle);
  assign cfg_err = cfg_err_q;
  assign state   = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_ok) state_d = StLoad;
      StLoad:  if (coeff_hs && (coef_cnt_q == tap_q - TW'(1))) state_d = StRun;
      StRun:   if (cfg_stop) state_d = StDrain;
      StDrain: if (!in_flight_q && (cnt_q == 2'd0)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tap_q       <= '0;
      coef_cnt_q  <= '0;
      pulse_q     <= 1'b0;
      cfg_err_q   <= 1'b0;
      in_flight_q <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      pulse_q     <= start_ok;
      in_flight_q <= in_hs;

      if (start_ok) begin
        tap_q     <= cfg_tap_count;
        cfg_err_q <= 1'b0;
      end else if ((state_q == StIdle) && cfg_start) begin
        cfg_err_q <= 1'b1;
      end

      if (state_q != StLoad) begin
        coef_cnt_q <= '0;
      end else if (coeff_hs) begin
        coef_cnt_q <= coef_cnt_q + TW'(1);
      end

      if (push) begin
        fifo_q[wr_ptr_q] <= dp_output_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_control.sv
// Self-checking bench for fir_control: a behavioural FIR datapath stand-in plus a convolution
// reference model computed directly from the coefficient and sample lists.
module tb_fir_control;
  localparam int unsigned MAX_TAPS = 16;
  localparam int unsigned TW = $clog2(MAX_TAPS);

  logic clk = 1'b0;
  logic rst;
  logic cfg_start, cfg_stop;
  logic [TW-1:0] cfg_tap_count;
  logic s_coeff_valid, s_coeff_ready;
  logic signed [31:0] s_coeff_data;
  logic s_in_valid, s_in_ready;
  logic signed [31:0] s_in_data;
  logic m_out_valid, m_out_ready;
  logic signed [31:0] m_out_data;
  logic dp_rstn, dp_input_data_valid, dp_coeff_data_valid, dp_compute;
  logic [TW-1:0] dp_tap_count;
  logic [31:0] dp_input_data, dp_coeff_data;
  logic signed [31:0] dp_output_data = '0;
  logic dp_output_data_valid = 1'b0;
  logic busy, cfg_err;
  logic [1:0] state;

  int n_pass = 0, n_total = 0;
  int cq[$], xq[$], exp_q[$], got[$];
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  fir_control #(.MAX_TAPS(MAX_TAPS)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_tap_count(cfg_tap_count), .cfg_stop(cfg_stop),
    .s_coeff_valid(s_coeff_valid), .s_coeff_data(s_coeff_data), .s_coeff_ready(s_coeff_ready),
    .s_in_valid(s_in_valid), .s_in_data(s_in_data), .s_in_ready(s_in_ready),
    .m_out_valid(m_out_valid), .m_out_data(m_out_data), .m_out_ready(m_out_ready),
    .dp_rstn(dp_rstn), .dp_tap_count(dp_tap_count),
    .dp_input_data_valid(dp_input_data_valid), .dp_input_data(dp_input_data),
    .dp_coeff_data_valid(dp_coeff_data_valid), .dp_coeff_data(dp_coeff_data),
    .dp_compute(dp_compute),
    .dp_output_data(dp_output_data), .dp_output_data_valid(dp_output_data_valid),
    .busy(busy), .cfg_err(cfg_err), .state(state)
  );

  // Datapath stand-in: one-cycle latency, no result until tap_count samples have been seen.
  int dcoef [MAX_TAPS];
  int dhist [MAX_TAPS];
  int dn_coef = 0, dn_samp = 0;

  function automatic int dp_sum(input int x);
    int acc;
    acc = dcoef[0] * x;
    for (int k = 1; k < MAX_TAPS; k++) if (k < int'(dp_tap_count)) acc += dcoef[k] * dhist[k-1];
    return acc;
  endfunction

  always @(posedge clk) begin
    dp_output_data_valid <= 1'b0;
    if (!dp_rstn) begin
      dn_coef <= 0;
      dn_samp <= 0;
      for (int k = 0; k < MAX_TAPS; k++) begin dcoef[k] <= 0; dhist[k] <= 0; end
    end else begin
      if (dp_coeff_data_valid && dn_coef < MAX_TAPS) begin
        dcoef[dn_coef] <= int'(dp_coeff_data);
        dn_coef <= dn_coef + 1;
      end
      if (dp_input_data_valid) begin
        dp_output_data       <= dp_sum(int'(dp_input_data));
        dp_output_data_valid <= (dn_samp + 1 >= int'(dp_tap_count));
        dn_samp              <= dn_samp + 1;
        dhist[0]             <= int'(dp_input_data);
        for (int k = 1; k < MAX_TAPS; k++) dhist[k] <= dhist[k-1];
      end
    end
  end

  // Result collector and optional random consumer.
  initial forever begin
    @(negedge clk);
    if (m_out_valid && m_out_ready) got.push_back(int'(m_out_data));
  end
  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) m_out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: y[n] = sum_k c[k] * x[n-k], only for n with a full window.
  function automatic void build_expected(input int taps);
    exp_q.delete();
    for (int n = taps - 1; n < xq.size(); n++) begin
      int acc;
      acc = 0;
      for (int k = 0; k < taps; k++) acc += cq[k] * xq[n-k];
      exp_q.push_back(acc);
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_cfg(input logic [TW-1:0] t);
    cfg_start = 1'b1; cfg_tap_count = t;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_coeffs(input int n, output bit ok);
    bit hs; int b;
    ok = 1'b1;
    for (int i = 0; i < n && ok; i++) begin
      s_coeff_valid = 1'b1; s_coeff_data = cq[i]; hs = 1'b0; b = 0;
      while (!hs && b < 50) begin @(negedge clk); hs = s_coeff_ready; b++; tick(); end
      ok = hs;
    end
    s_coeff_valid = 1'b0;
  endtask

  task automatic send_samples(input int from, input int n, input bit gaps, output bit ok);
    bit hs; int b;
    ok = 1'b1;
    for (int i = from; i < from + n && ok; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin s_in_valid = 1'b0; tick(); end
      s_in_valid = 1'b1; s_in_data = xq[i]; hs = 1'b0; b = 0;
      while (!hs && b < 200) begin @(negedge clk); hs = s_in_ready; b++; tick(); end
      ok = hs;
    end
    s_in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, output bit ok);
    int b;
    b = 0;
    while (got.size() < n && b < 1000) begin tick(); b++; end
    ok = (got.size() >= n);
  endtask

  task automatic stop_drain(output bit ok);
    int b;
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    b = 0;
    while (state != 2'd0 && b < 200) begin tick(); b++; end
    ok = (state == 2'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 0; cfg_stop = 0; cfg_tap_count = '0; s_coeff_valid = 0;
    s_coeff_data = '0; s_in_valid = 0; s_in_data = '0; m_out_ready = 0;
    tick(); tick();
    @(negedge clk);
    n_total++; if (state !== 2'd0) $display("FAIL rst_state: got %0d want 0", state); else n_pass++;
    n_total++; if (dp_rstn !== 1'b0) $display("FAIL rst_dp_rstn: got %b want 0", dp_rstn); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (cfg_err !== 1'b0) $display("FAIL rst_cfg_err: got %b want 0", cfg_err); else n_pass++;
    n_total++; if (dp_tap_count !== '0) $display("FAIL rst_tap: got %0d want 0", dp_tap_count); else n_pass++;
    n_total++; if ({s_coeff_ready, s_in_ready, m_out_valid} !== 3'b000)
      $display("FAIL rst_handshake: got %b want 000", {s_coeff_ready, s_in_ready, m_out_valid});
    else n_pass++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (dp_rstn !== 1'b1) $display("FAIL rst_release_dp_rstn: got %b want 1", dp_rstn); else n_pass++;
    tick();
  endtask

  task automatic test_happy();
    bit ok;
    got.delete(); m_out_ready = 1'b1;
    cq = '{1, 1, 1, 1};
    xq.delete(); for (int i = 0; i < 12; i++) xq.push_back(5);
    build_expected(4);
    start_cfg(4'd4);
    @(negedge clk);
    n_total++; if (state !== 2'd1) $display("FAIL happy_load_state: got %0d want 1", state); else n_pass++;
    n_total++; if (dp_rstn !== 1'b0) $display("FAIL happy_rstn_pulse: got %b want 0", dp_rstn); else n_pass++;
    n_total++; if (s_coeff_ready !== 1'b0) $display("FAIL happy_ready_in_pulse: got %b want 0", s_coeff_ready); else n_pass++;
    n_total++; if (dp_tap_count !== 4'd4) $display("FAIL happy_tap: got %0d want 4", dp_tap_count); else n_pass++;
    tick();
    send_coeffs(4, ok);
    n_total++; if (!ok) $display("FAIL happy_coeffs: got timeout want accepted"); else n_pass++;
    @(negedge clk);
    n_total++; if ({state, dp_compute} !== 3'b101) $display("FAIL happy_run: got %b want 101", {state, dp_compute}); else n_pass++;
    tick();
    send_samples(0, 12, 1'b0, ok);
    wait_results(9, ok);
    repeat (5) tick();
    n_total++; if (got.size() !== 9) $display("FAIL happy_count: got %0d want 9", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 9; i++) begin
      n_total++; if (got[i] !== 20) $display("FAIL happy_value[%0d]: got %0d want 20", i, got[i]); else n_pass++;
    end
    stop_drain(ok);
    n_total++; if ({state, busy} !== 3'b000) $display("FAIL happy_idle: got %b want 000", {state, busy}); else n_pass++;
  endtask

  task automatic test_illegal_cfg();
    logic [TW-1:0] bad [3];
    logic [31:0] wide;
    wide = MAX_TAPS;
    bad[0] = '0; bad[1] = TW'(1); bad[2] = wide[TW-1:0];
    for (int i = 0; i < 3; i++) begin
      start_cfg(bad[i]);
      @(negedge clk);
      n_total++; if (cfg_err !== 1'b1) $display("FAIL illegal_err[%0d]: got %b want 1", i, cfg_err); else n_pass++;
      n_total++; if (state !== 2'd0) $display("FAIL illegal_state[%0d]: got %0d want 0", i, state); else n_pass++;
      n_total++; if (dp_rstn !== 1'b1) $display("FAIL illegal_no_pulse[%0d]: got %b want 1", i, dp_rstn); else n_pass++;
      n_total++; if (dp_tap_count !== 4'd4) $display("FAIL illegal_tap[%0d]: got %0d want 4", i, dp_tap_count); else n_pass++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit ok, hs;
    int acc;
    got.delete(); m_out_ready = 1'b0;
    cq = '{3, -2};
    xq = '{11, -7, 4, 9, 100};
    build_expected(2);
    start_cfg(4'd2);
    @(negedge clk);
    n_total++; if (cfg_err !== 1'b0) $display("FAIL bp_err_cleared: got %b want 0", cfg_err); else n_pass++;
    tick();
    send_coeffs(2, ok);
    s_in_valid = 1'b1; s_in_data = xq[0]; acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); hs = s_in_ready;
      tick();
      if (hs) begin acc++; if (acc < xq.size()) s_in_data = xq[acc]; end
    end
    s_in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (acc !== 3) $display("FAIL bp_accepted: got %0d want 3", acc); else n_pass++;
    n_total++; if (s_in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", s_in_ready); else n_pass++;
    n_total++; if (m_out_data !== exp_q[0]) $display("FAIL bp_head: got %0d want %0d", m_out_data, exp_q[0]); else n_pass++;
    tick(); tick();
    @(negedge clk);
    n_total++; if (m_out_valid !== 1'b1 || m_out_data !== exp_q[0])
      $display("FAIL bp_hold: got %0d want %0d", m_out_data, exp_q[0]);
    else n_pass++;
    tick();
    m_out_ready = 1'b1;
    send_samples(3, 2, 1'b0, ok);
    wait_results(4, ok);
    repeat (4) tick();
    n_total++; if (got.size() !== exp_q.size()) $display("FAIL bp_count: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_total++; if (got[i] !== exp_q[i]) $display("FAIL bp_order[%0d]: got %0d want %0d", i, got[i], exp_q[i]); else n_pass++;
    end
    stop_drain(ok);
  endtask

  task automatic test_push_pop();
    bit ok;
    got.delete(); m_out_ready = 1'b0;
    cq = '{5, 1};
    xq = '{2, 3, 4};
    build_expected(2);
    start_cfg(4'd2);
    tick();
    send_coeffs(2, ok);
    send_samples(0, 2, 1'b0, ok);
    tick();
    send_samples(2, 1, 1'b0, ok);
    // One result buffered, the next arriving this cycle while the head is popped.
    m_out_ready = 1'b1;
    @(negedge clk);
    n_total++; if (m_out_data !== exp_q[0]) $display("FAIL pp_first: got %0d want %0d", m_out_data, exp_q[0]); else n_pass++;
    tick();
    m_out_ready = 1'b0;
    @(negedge clk);
    n_total++; if (m_out_valid !== 1'b1 || m_out_data !== exp_q[1])
      $display("FAIL pp_second: got %0d want %0d", m_out_data, exp_q[1]);
    else n_pass++;
    tick();
    m_out_ready = 1'b1;
    wait_results(2, ok);
    repeat (3) tick();
    n_total++; if (got.size() !== 2) $display("FAIL pp_count: got %0d want 2", got.size()); else n_pass++;
    stop_drain(ok);
  endtask

  task automatic test_stop_backpressure();
    bit ok, drained_early;
    got.delete(); m_out_ready = 1'b0;
    cq = '{1, 2};
    xq = '{1, 2, 3};
    start_cfg(4'd2);
    tick();
    send_coeffs(2, ok);
    send_samples(0, 3, 1'b0, ok);
    tick(); tick();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    drained_early = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); if (state !== 2'd3 || dp_compute !== 1'b0 || s_in_ready !== 1'b0) drained_early = 1'b1;
      tick();
    end
    n_total++; if (drained_early) $display("FAIL stop_bp_hold: got left DRAIN want DRAIN"); else n_pass++;
    m_out_ready = 1'b1; tick(); m_out_ready = 1'b0;
    @(negedge clk);
    n_total++; if ({state, m_out_valid} !== 3'b111) $display("FAIL stop_bp_one_left: got %b want 111", {state, m_out_valid}); else n_pass++;
    tick();
    m_out_ready = 1'b1;
    tick(); tick();
    m_out_ready = 1'b0;
    @(negedge clk);
    n_total++; if (state !== 2'd0) $display("FAIL stop_bp_idle: got %0d want 0", state); else n_pass++;
    n_total++; if (got.size() !== 2) $display("FAIL stop_bp_count: got %0d want 2", got.size()); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    got.delete(); m_out_ready = 1'b1;
    cq = '{7, 7, 7, 7};
    start_cfg(4'd4);
    tick();
    send_coeffs(2, ok);
    rst = 1'b1;
    @(negedge clk);
    n_total++; if ({s_coeff_ready, dp_rstn} !== 2'b00) $display("FAIL rml_in_rst: got %b want 00", {s_coeff_ready, dp_rstn}); else n_pass++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_total++; if ({state, dp_rstn} !== 3'b001) $display("FAIL rml_idle: got %b want 001", {state, dp_rstn}); else n_pass++;
    tick();
    cq = '{2, -3, 4, 5};
    xq = '{1, 0, 0, 0, 0, 6, -2, 9};
    build_expected(4);
    start_cfg(4'd4);
    tick();
    send_coeffs(4, ok);
    send_samples(0, 8, 1'b0, ok);
    wait_results(exp_q.size(), ok);
    repeat (4) tick();
    n_total++; if (got.size() !== exp_q.size()) $display("FAIL rml_count: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_total++; if (got[i] !== exp_q[i]) $display("FAIL rml_value[%0d]: got %0d want %0d", i, got[i], exp_q[i]); else n_pass++;
    end
    stop_drain(ok);
  endtask

  task automatic test_random();
    bit ok;
    int taps, ns;
    for (int it = 0; it < 3; it++) begin
      got.delete(); rand_ready = 1'b1;
      taps = $urandom_range(2, MAX_TAPS - 1);
      ns = $urandom_range(20, 30);
      cq.delete(); xq.delete();
      for (int k = 0; k < taps; k++) cq.push_back(int'($urandom_range(0, 2000)) - 1000);
      for (int k = 0; k < ns; k++) xq.push_back(int'($urandom()));
      build_expected(taps);
      start_cfg(TW'(taps));
      tick();
      send_coeffs(taps, ok);
      send_samples(0, ns, 1'b1, ok);
      n_total++; if (!ok) $display("FAIL rand_samples[%0d]: got timeout want accepted", it); else n_pass++;
      wait_results(exp_q.size(), ok);
      n_total++; if (got.size() !== exp_q.size()) $display("FAIL rand_count[%0d]: got %0d want %0d", it, got.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        n_total++; if (got[i] !== exp_q[i]) $display("FAIL rand_value[%0d.%0d]: got %0d want %0d", it, i, got[i], exp_q[i]); else n_pass++;
      end
      stop_drain(ok);
      n_total++; if (!ok) $display("FAIL rand_drain[%0d]: got state %0d want 0", it, state); else n_pass++;
      rand_ready = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_illegal_cfg();
    test_backpressure();
    test_push_pop();
    test_stop_backpressure();
    test_reset_mid_load();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
